load_unit: RTL
==============

Name: load_unit

Overview:
Data-memory read-side counterpart of the S-type store byte-enable logic. Accepts a decoded I-type load (LB/LH/LW/LBU/LHU) plus effective address, issues one word-aligned read on the data-memory port, waits for the ack, then byte/half-lane selects and sign- or zero-extends into rd_data. Sits between execute stage and data memory. Flags misaligned/illegal loads and memory timeouts instead of issuing or hanging.

Parameters:
TIMEOUT_CYCLES, 16, max cycles in REQ without mem_ack before fault; must be >= 1
CNT_W, 5, width of timeout counter; must satisfy 2**CNT_W > TIMEOUT_CYCLES

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous, active-high reset
start  input  1  one-cycle load request; sampled only in IDLE
instr  input  32  load instruction; funct3 = instr[14:12]
daddr  input  32  effective byte address
busy  output  1  high in every state except IDLE
done  output  1  one-cycle pulse in DONE
rd_data  output  32  extended load result; held until next start
fault  output  1  valid with done; 1 = misaligned, illegal funct3 or timeout
mem_req  output  1  read request, held high until mem_ack
mem_addr  output  32  {daddr[31:2],2'b00}, stable while mem_req
mem_ack  input  1  memory response valid
mem_rdata  input  32  read word, valid with mem_ack

Behaviour:
- Reset (async, any state): state=IDLE; busy, done, fault, mem_req = 0; rd_data, mem_addr = 0; timeout counter = 0.
- States: IDLE, REQ, DONE.
- IDLE: on start=1, register funct3, daddr[1:0], mem_addr. If legal and aligned -> REQ; else -> DONE with fault=1, rd_data=0, mem_req never asserted.
- Legal funct3: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. Others (011,110,111) illegal.
- Alignment: LH/LHU need daddr[0]=0; LW needs daddr[1:0]=00; bytes always aligned.
- REQ: mem_req=1. At the rising edge where mem_ack=1: capture extended mem_rdata into rd_data, fault=0 -> DONE. Otherwise increment counter; when counter reaches TIMEOUT_CYCLES-1 with no ack -> DONE with fault=1, rd_data=0.
- Ack on the same edge as the timeout limit: the ack wins (no fault).
- mem_ack while not in REQ: ignored.
- DONE: done=1 for exactly one cycle -> IDLE. Counter cleared.
- Latency: aligned load with ack in the first REQ cycle gives start at edge N, mem_req high after N, capture at N+1, done high during cycle N+2. Fault path gives done during cycle N+1.
- start while busy: ignored. start asserted in DONE is also ignored, so the earliest back-to-back start is the following IDLE cycle.
- Lane select: byte = mem_rdata[8*off +: 8] with off=daddr[1:0]; half = mem_rdata[16*off[1] +: 16].
- Extension: LB/LH replicate the MSB of the selected field to bit 31; LBU/LHU zero-fill; LW passes through.
- Little-endian, matching store byte-enable lane order (SB=0001 at offset 0).

Decomposition:
- Shared package LoadPackage: enum LoadFunct3 (LB=3'b000, LH=3'b001, LW=3'b010, LBU=3'b100, LHU=3'b101); enum LoadState (IDLE, REQ, DONE). Placed beside the existing store-type package.
- Sub-module load_extract (combinational): inputs funct3, offset[1:0], word[31:0]; outputs ext_data[31:0], legal, aligned. Instantiated once by load_unit. The FSM, counter and registers stay in the top module.

Test Plan:
- LB, daddr=0x1003, mem_rdata=0x80FF1234, ack on first REQ cycle -> mem_addr=0x1000, done after 2 cycles, rd_data=0xFFFFFF80, fault=0.
- LBU, same stimulus -> rd_data=0x00000080; then LHU with daddr=0x1002, mem_rdata=0x80010000 -> 0x00008001; LH, same stimulus -> 0xFFFF8001.
- LW with daddr=0x1006 -> mem_req never high, done one cycle after start, fault=1, rd_data=0. funct3=011 -> same result.
- LW at daddr=0x2000 with mem_ack held low -> fault=1, rd_data=0, done exactly TIMEOUT_CYCLES cycles after mem_req rises. Repeat with ack arriving on the limit cycle -> fault=0.
- Assert rst mid-REQ -> mem_req and busy drop immediately (async). A subsequent LW at 0x3000 with rdata 0xDEADBEEF returns 0xDEADBEEF.
- start pulsed while busy and again in DONE -> ignored; exactly one mem_req and one done pulse per accepted start; rd_data holds its value through IDLE.

Source files
------------

// File: rtl/load_unit_pkg.sv
// Shared load-side types: funct3 encodings for I-type loads and the load FSM states.
package load_unit_pkg;
  typedef enum logic [2:0] {
    LB  = 3'b000,
    LH  = 3'b001,
    LW  = 3'b010,
    LBU = 3'b100,
    LHU = 3'b101
  } load_funct3_e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } load_state_e;
endpackage

// File: rtl/load_unit_if.sv
// Word-aligned data-memory read port: request held until ack, data valid with ack.
interface load_unit_if;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;

  modport master (output mem_req, output mem_addr, input mem_ack, input mem_rdata);
  modport slave  (input mem_req, input mem_addr, output mem_ack, output mem_rdata);
endinterface

// File: rtl/load_unit_extract.sv
// Combinational lane select plus sign/zero extension, with legality and alignment flags.
module load_extract
  import load_unit_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  offset,
  input  logic [31:0] word,
  output logic [31:0] ext_data,
  output logic        legal,
  output logic        aligned
);
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Little-endian lanes: offset 0 is word[7:0], same order as store byte enables.
  assign byte_sel = word[8*offset +: 8];
  assign half_sel = offset[1] ? word[31:16] : word[15:0];

  always_comb begin
    ext_data = '0;
    legal    = 1'b1;
    aligned  = 1'b1;
    case (funct3)
      LB:  ext_data = {{24{byte_sel[7]}}, byte_sel};
      LBU: ext_data = {24'h0, byte_sel};
      LH: begin
        ext_data = {{16{half_sel[15]}}, half_sel};
        aligned  = ~offset[0];
      end
      LHU: begin
        ext_data = {16'h0, half_sel};
        aligned  = ~offset[0];
      end
      LW: begin
        ext_data = word;
        aligned  = (offset == 2'b00);
      end
      default: legal = 1'b0;
    endcase
  end
endmodule

// File: rtl/load_unit.sv
// Load unit: one aligned read per accepted load, then lane-extract into rd_data;
// misaligned/illegal loads and memory timeouts finish with fault instead.
module load_unit
  import load_unit_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16,
  parameter int CNT_W          = 5
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic [31:0]       instr,
  input  logic [31:0]       daddr,
  output logic              busy,
  output logic              done,
  output logic [31:0]       rd_data,
  output logic              fault,
  load_unit_if.master       mem
);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(TIMEOUT_CYCLES - 1);

  load_state_e      state;
  logic [2:0]       funct3_q;
  logic [1:0]       off_q;
  logic [CNT_W-1:0] cnt;

  logic [2:0]  f3_sel;
  logic [1:0]  off_sel;
  logic [31:0] ext_data;
  logic        legal, aligned;
  logic        unused_bits;

  assign unused_bits = ^{instr[31:15], instr[11:0]};

  // One extractor serves both the IDLE legality check (live inputs) and the
  // REQ capture (registered funct3/offset).
  assign f3_sel  = (state == IDLE) ? instr[14:12] : funct3_q;
  assign off_sel = (state == IDLE) ? daddr[1:0]   : off_q;

  load_extract u_extract (
    .funct3   (f3_sel),
    .offset   (off_sel),
    .word     (mem.mem_rdata),
    .ext_data (ext_data),
    .legal    (legal),
    .aligned  (aligned)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state        <= IDLE;
      busy         <= 1'b0;
      done         <= 1'b0;
      fault        <= 1'b0;
      rd_data      <= '0;
      mem.mem_req  <= 1'b0;
      mem.mem_addr <= '0;
      funct3_q     <= '0;
      off_q        <= '0;
      cnt          <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: if (start) begin
          funct3_q     <= instr[14:12];
          off_q        <= daddr[1:0];
          mem.mem_addr <= {daddr[31:2], 2'b00};
          busy         <= 1'b1;
          if (legal && aligned) begin
            state       <= REQ;
            mem.mem_req <= 1'b1;
          end else begin
            state   <= DONE;
            done    <= 1'b1;
            fault   <= 1'b1;
            rd_data <= '0;
          end
        end
        REQ: begin
          // Ack is checked first so an ack on the limit cycle still completes cleanly.
          if (mem.mem_ack) begin
            state       <= DONE;
            done        <= 1'b1;
            fault       <= 1'b0;
            rd_data     <= ext_data;
            mem.mem_req <= 1'b0;
          end else if (cnt == CNT_LIMIT) begin
            state       <= DONE;
            done        <= 1'b1;
            fault       <= 1'b1;
            rd_data     <= '0;
            mem.mem_req <= 1'b0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        DONE: begin
          state <= IDLE;
          busy  <= 1'b0;
          cnt   <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule
